// File: rtl/mips_cpu_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_regfile_wb_arbiter
// Purpose  : Shares the single register-file write port between pipeline
//            writeback (port A, never stalled) and a buffered mul/div result
//            path (port B). Tracks outstanding B destinations in a pending
//            scoreboard and requests a pipeline hold when B results starve.
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_regfile_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    input  logic [5:0]  a_opcode,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_reg,
    output logic        rf_regwrite,
    output logic [4:0]  rf_writereg,
    output logic [31:0] rf_writedata,
    output logic [5:0]  rf_opcode,
    output logic [31:0] pending,
    output logic        hold_req
);

    // Storage is always sized for the largest legal depth so that the 2-bit
    // pointers index it cleanly; only the first DEPTH entries are ever used.
    localparam int         c_MAX_DEPTH = 4;
    localparam logic [2:0] c_DEPTH     = 3'(DEPTH);
    localparam logic [1:0] c_LAST_PTR  = 2'(DEPTH - 1);
    localparam logic [3:0] c_LIMIT     = 4'(STARVE_LIMIT);
    localparam logic [3:0] c_WAIT_MAX  = 4'd15;

    logic [4:0]  r_buf_reg_q [c_MAX_DEPTH];
    logic [31:0] r_buf_dat_q [c_MAX_DEPTH];

    logic [1:0]  r_rd_ptr_q, w_rd_ptr_d;
    logic [1:0]  r_wr_ptr_q, w_wr_ptr_d;
    logic [2:0]  r_count_q,  w_count_d;
    logic [3:0]  r_wait_q,   w_wait_d;
    logic        r_hold_q,   w_hold_d;
    logic        r_popped_q, w_popped_d;
    logic        r_we_q,     w_we_d;
    logic [4:0]  r_wreg_q,   w_wreg_d;
    logic [31:0] r_wdat_q,   w_wdat_d;
    logic [5:0]  r_opc_q,    w_opc_d;
    logic [31:0] r_pend_q,   w_pend_d;

    logic        w_a_win;
    logic        w_not_empty;
    logic        w_pop;
    logic        w_push;
    logic [4:0]  w_head_reg;
    logic [31:0] w_head_dat;

    // Ready depends only on registered occupancy: a full buffer stays not-ready
    // even when it is being drained this cycle.
    assign b_ready      = (r_count_q < c_DEPTH) && !reset;
    assign rf_regwrite  = r_we_q;
    assign rf_writereg  = r_wreg_q;
    assign rf_writedata = r_wdat_q;
    assign rf_opcode    = r_opc_q;
    assign pending      = r_pend_q;
    assign hold_req     = r_hold_q;

    // Arbitration, FIFO bookkeeping, scoreboard and starvation tracking.
    always_comb begin
        w_a_win     = a_valid && (a_reg != 5'd0);
        w_not_empty = (r_count_q != 3'd0);
        w_pop       = !w_a_win && w_not_empty;
        w_push      = b_valid && b_ready && (b_reg != 5'd0);
        w_head_reg  = r_buf_reg_q[r_rd_ptr_q];
        w_head_dat  = r_buf_dat_q[r_rd_ptr_q];

        w_rd_ptr_d  = r_rd_ptr_q;
        w_wr_ptr_d  = r_wr_ptr_q;
        w_count_d   = r_count_q;
        w_we_d      = 1'b0;
        w_wreg_d    = r_wreg_q;
        w_wdat_d    = r_wdat_q;
        w_opc_d     = r_opc_q;
        w_pend_d    = r_pend_q;
        w_wait_d    = r_wait_q;
        w_popped_d  = w_pop;

        if (w_a_win) begin
            w_we_d   = 1'b1;
            w_wreg_d = a_reg;
            w_wdat_d = a_data;
            w_opc_d  = a_opcode;
        end else if (w_pop) begin
            // B results are full words, so the register file takes its
            // plain-store path.
            w_we_d             = 1'b1;
            w_wreg_d           = w_head_reg;
            w_wdat_d           = w_head_dat;
            w_opc_d            = 6'b000000;
            w_pend_d[w_head_reg] = 1'b0;
        end

        if (w_pop) begin
            w_rd_ptr_d = (r_rd_ptr_q == c_LAST_PTR) ? 2'd0 : r_rd_ptr_q + 2'd1;
        end
        if (w_push) begin
            w_wr_ptr_d = (r_wr_ptr_q == c_LAST_PTR) ? 2'd0 : r_wr_ptr_q + 2'd1;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + 3'd1;
            2'b01:   w_count_d = r_count_q - 3'd1;
            default: w_count_d = r_count_q;
        endcase

        // A fresh issue must win over a retiring result to the same register.
        if (issue_valid && (issue_reg != 5'd0)) begin
            w_pend_d[issue_reg] = 1'b1;
        end

        if (w_pop || !w_not_empty) begin
            w_wait_d = 4'd0;
        end else if (r_wait_q != c_WAIT_MAX) begin
            w_wait_d = r_wait_q + 4'd1;
        end

        // Hold releases one edge after a pop; it is re-raised by the counter.
        w_hold_d = (r_hold_q && !r_popped_q) || (w_wait_d >= c_LIMIT);
    end

    // Result buffer storage; contents need no reset because occupancy gates use.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_reg_q[r_wr_ptr_q] <= b_reg;
            r_buf_dat_q[r_wr_ptr_q] <= b_data;
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr_q <= 2'd0;
            r_wr_ptr_q <= 2'd0;
            r_count_q  <= 3'd0;
            r_wait_q   <= 4'd0;
            r_hold_q   <= 1'b0;
            r_popped_q <= 1'b0;
            r_we_q     <= 1'b0;
            r_wreg_q   <= 5'd0;
            r_wdat_q   <= 32'd0;
            r_opc_q    <= 6'd0;
            r_pend_q   <= 32'd0;
        end else begin
            r_rd_ptr_q <= w_rd_ptr_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_count_q  <= w_count_d;
            r_wait_q   <= w_wait_d;
            r_hold_q   <= w_hold_d;
            r_popped_q <= w_popped_d;
            r_we_q     <= w_we_d;
            r_wreg_q   <= w_wreg_d;
            r_wdat_q   <= w_wdat_d;
            r_opc_q    <= w_opc_d;
            r_pend_q   <= w_pend_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_cpu_regfile_wb_arbiter
// Purpose  : Directed self-checking bench for the register-file write-port
//            arbiter, with a queue-based reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_regfile_wb_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, issue_valid;
    logic [4:0]  a_reg, b_reg, issue_reg;
    logic [31:0] a_data, b_data;
    logic [5:0]  a_opcode;
    logic        b_ready, rf_regwrite, hold_req;
    logic [4:0]  rf_writereg;
    logic [31:0] rf_writedata, pending;
    logic [5:0]  rf_opcode;

    int n_checks = 0;
    int n_fail   = 0;

    mips_cpu_regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_opcode(a_opcode),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .issue_valid(issue_valid), .issue_reg(issue_reg),
        .rf_regwrite(rf_regwrite), .rf_writereg(rf_writereg),
        .rf_writedata(rf_writedata), .rf_opcode(rf_opcode),
        .pending(pending), .hold_req(hold_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [4:0]  mq_reg[$];
    logic [31:0] mq_dat[$];
    bit          m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_dat;
    logic [5:0]  m_opc;
    logic [31:0] m_pend;
    int          m_wait;
    bit          m_hold, m_popped;

    always @(posedge clk or posedge reset) begin
        int sz;
        bit a_win, pop, rdy;
        if (reset) begin
            mq_reg.delete(); mq_dat.delete();
            m_we = 0; m_reg = 0; m_dat = 0; m_opc = 0; m_pend = 0;
            m_wait = 0; m_hold = 0; m_popped = 0;
        end else begin
            sz    = mq_reg.size();
            rdy   = (sz < DEPTH);
            a_win = a_valid && (a_reg != 0);
            pop   = !a_win && (sz > 0);
            if (a_win) begin
                m_we = 1; m_reg = a_reg; m_dat = a_data; m_opc = a_opcode;
            end else if (pop) begin
                m_we = 1; m_reg = mq_reg.pop_front(); m_dat = mq_dat.pop_front(); m_opc = 0;
                m_pend[m_reg] = 1'b0;
            end else begin
                m_we = 0;
            end
            if (b_valid && rdy && (b_reg != 0)) begin
                mq_reg.push_back(b_reg);
                mq_dat.push_back(b_data);
            end
            if (issue_valid && (issue_reg != 0)) m_pend[issue_reg] = 1'b1;
            if (pop || sz == 0) m_wait = 0;
            else if (m_wait < 15) m_wait++;
            m_hold   = (m_hold && !m_popped) || (m_wait >= STARVE_LIMIT);
            m_popped = pop;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_regwrite", {31'd0, rf_regwrite}, {31'd0, m_we});
        chk("cyc_writereg", {27'd0, rf_writereg}, {27'd0, m_reg});
        chk("cyc_writedata", rf_writedata, m_dat);
        chk("cyc_opcode", {26'd0, rf_opcode}, {26'd0, m_opc});
        chk("cyc_pending", pending, m_pend);
        chk("cyc_hold_req", {31'd0, hold_req}, {31'd0, m_hold});
        chk("cyc_b_ready", {31'd0, b_ready}, {31'd0, (!reset && (mq_reg.size() < DEPTH))});
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b1;
        a_valid = 0; a_reg = 0; a_data = 0; a_opcode = 0;
        b_valid = 0; b_reg = 0; b_data = 0;
        issue_valid = 0; issue_reg = 0;
        repeat (3) cyc();
        chk("rst_regwrite", {31'd0, rf_regwrite}, 32'd0);
        chk("rst_writedata", rf_writedata, 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
        reset = 1'b0;
        cyc();
        chk("rel_b_ready", {31'd0, b_ready}, 32'd1);

        // 1: port A write
        a_valid = 1; a_reg = 5; a_data = 32'h1234; a_opcode = 6'b100011;
        cyc();
        chk("t1_regwrite", {31'd0, rf_regwrite}, 32'd1);
        chk("t1_writereg", {27'd0, rf_writereg}, 32'd5);
        chk("t1_writedata", rf_writedata, 32'h1234);
        chk("t1_opcode", {26'd0, rf_opcode}, 32'h23);
        a_valid = 0;

        // 2: issue, then B result retires
        issue_valid = 1; issue_reg = 9;
        cyc();
        chk("t2_pending_set", pending, 32'h200);
        issue_valid = 0;
        b_valid = 1; b_reg = 9; b_data = 32'hDEAD;
        cyc();
        b_valid = 0;
        chk("t2_no_write_yet", {31'd0, rf_regwrite}, 32'd0);
        cyc();
        chk("t2_writereg", {27'd0, rf_writereg}, 32'd9);
        chk("t2_writedata", rf_writedata, 32'hDEAD);
        chk("t2_opcode", {26'd0, rf_opcode}, 32'd0);
        chk("t2_pending_clr", pending, 32'd0);

        // 3: fill buffer behind port A, then drain in order
        a_valid = 1; a_reg = 7; a_data = 32'h77; a_opcode = 6'h23;
        b_valid = 1; b_reg = 3; b_data = 32'h333;
        cyc();
        chk("t3_ready_one", {31'd0, b_ready}, 32'd1);
        b_reg = 4; b_data = 32'h444;
        cyc();
        b_valid = 0;
        chk("t3_ready_full", {31'd0, b_ready}, 32'd0);
        chk("t3_a_wins", {27'd0, rf_writereg}, 32'd7);
        a_valid = 0;
        cyc();
        chk("t3_first_reg", {27'd0, rf_writereg}, 32'd3);
        chk("t3_first_data", rf_writedata, 32'h333);
        cyc();
        chk("t3_second_reg", {27'd0, rf_writereg}, 32'd4);
        cyc();
        chk("t3_idle", {31'd0, rf_regwrite}, 32'd0);
        chk("t3_hold_reg", {27'd0, rf_writereg}, 32'd4);

        // 4: starvation raises hold_req
        a_valid = 1; a_reg = 7;
        b_valid = 1; b_reg = 10; b_data = 32'hAAAA;
        cyc();
        b_valid = 0;
        repeat (3) cyc();
        chk("t4_hold_low", {31'd0, hold_req}, 32'd0);
        cyc();
        chk("t4_hold_high", {31'd0, hold_req}, 32'd1);
        a_valid = 0;
        cyc();
        chk("t4_drain_reg", {27'd0, rf_writereg}, 32'd10);
        chk("t4_hold_still", {31'd0, hold_req}, 32'd1);
        cyc();
        chk("t4_hold_fall", {31'd0, hold_req}, 32'd0);

        // 5: a_reg=0 is idle; b_reg=0 is swallowed
        a_valid = 1; a_reg = 7;
        b_valid = 1; b_reg = 6; b_data = 32'h6666;
        cyc();
        b_valid = 0; a_reg = 0;
        cyc();
        chk("t5_b_reg", {27'd0, rf_writereg}, 32'd6);
        chk("t5_b_data", rf_writedata, 32'h6666);
        a_valid = 0;
        b_valid = 1; b_reg = 0; b_data = 32'hBAD;
        cyc();
        b_valid = 0;
        chk("t5_zero_pending", pending, 32'd0);
        chk("t5_zero_ready", {31'd0, b_ready}, 32'd1);
        cyc();
        chk("t5_zero_nowrite", {31'd0, rf_regwrite}, 32'd0);

        // 6a: issue and retire the same register together
        issue_valid = 1; issue_reg = 8;
        a_valid = 1; a_reg = 7;
        b_valid = 1; b_reg = 8; b_data = 32'h888;
        cyc();
        b_valid = 0; a_valid = 0;
        cyc();
        issue_valid = 0;
        chk("t6_set_wins", pending, 32'h100);
        chk("t6_pop_reg", {27'd0, rf_writereg}, 32'd8);

        // 6b: reset mid-operation with two entries buffered
        a_valid = 1; a_reg = 7; a_data = 32'h7777;
        issue_valid = 1; issue_reg = 11;
        b_valid = 1; b_reg = 11; b_data = 32'hB11;
        cyc();
        issue_reg = 12; b_reg = 12; b_data = 32'hB12;
        cyc();
        issue_valid = 0; b_valid = 0;
        chk("t6_pending_pre", pending, 32'h1900);
        reset = 1'b1;
        #1;
        chk("t6_rst_pending", pending, 32'd0);
        chk("t6_rst_regwrite", {31'd0, rf_regwrite}, 32'd0);
        chk("t6_rst_ready", {31'd0, b_ready}, 32'd0);
        cyc();
        reset = 1'b0; a_valid = 0;
        repeat (4) begin
            cyc();
            chk("t6_no_stale", {31'd0, rf_regwrite}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
